// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, ALUOp codes and control bundle shared by the ID/EX control slice
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] AOP_ADD   = 4'b0000;
  localparam logic [3:0] AOP_SUB   = 4'b0001;
  localparam logic [3:0] AOP_RTYPE = 4'b0010;
  localparam logic [3:0] AOP_AND   = 4'b0011;
  localparam logic [3:0] AOP_OR    = 4'b0100;
  localparam logic [3:0] AOP_SLT   = 4'b0101;

  typedef struct packed {
    logic [3:0] aluop;
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational opcode decoder
//   opcode   : instr[31:26]
//   ctrl     : ALUOp and datapath control bundle
//   uses_rs  : instruction reads rs
//   uses_rt  : instruction reads rt as a source
//   jump     : opcode is j
//   illegal  : opcode not recognised
module main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rs,
  output logic       uses_rt,
  output logic       jump,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NONE;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    jump    = 1'b0;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.aluop    = AOP_RTYPE;
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_LW: begin
        ctrl.aluop    = AOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        uses_rs       = 1'b1;
      end
      OP_SW: begin
        ctrl.aluop    = AOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluop  = AOP_SUB;
        ctrl.branch = 1'b1;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs       = 1'b1;
        case (opcode)
          OP_ANDI: ctrl.aluop = AOP_AND;
          OP_ORI:  ctrl.aluop = AOP_OR;
          OP_SLTI: ctrl.aluop = AOP_SLT;
          default: ctrl.aluop = AOP_ADD;
        endcase
      end
      OP_J:    jump    = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_control_stage.sv
// rtl/id_ex_control_stage.sv - ID decode, load-use hazard detection and ID/EX pipeline register
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid .. id_rd        : instruction fields held in IF/ID
//   flush                    : squash the ID-stage instruction
//   ext_stall                : freeze ID/EX
//   hazard_stall, id_jump    : combinational ID-stage outputs
//   ex_*                     : registered ID/EX contents
module id_ex_control_stage
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int OP_W  = 6,
  parameter int AOP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_opcode,
  input  logic [OP_W-1:0]  id_funct,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             hazard_stall,
  output logic             id_jump,
  output logic             ex_valid,
  output logic [AOP_W-1:0] ex_ALUOp,
  output logic [OP_W-1:0]  ex_funct,
  output logic             ex_RegDst,
  output logic             ex_ALUSrc,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic             ex_Branch,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_illegal
);

  ctrl_t dec_ctrl;
  logic  dec_uses_rs;
  logic  dec_uses_rt;
  logic  dec_jump;
  logic  dec_illegal;
  ctrl_t ex_ctrl;

  main_decoder u_main_decoder (
    .opcode  (id_opcode),
    .ctrl    (dec_ctrl),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt),
    .jump    (dec_jump),
    .illegal (dec_illegal)
  );

  // A load writing $0 produces nothing to wait for, so it never stalls.
  // A flushed ID instruction is discarded, so it cannot cause a stall either.
  assign hazard_stall = id_valid & ex_valid & ex_ctrl.memread & (ex_rt != '0) &
                        ((dec_uses_rs & (id_rs == ex_rt)) | (dec_uses_rt & (id_rt == ex_rt))) &
                        ~flush;

  assign id_jump = id_valid & dec_jump;

  // ext_stall outranks hazard_stall: the load stays in EX, so the stall persists.
  always_ff @(posedge clk) begin
    if (rst || flush || (!ext_stall && (hazard_stall || !id_valid))) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= CTRL_NONE;
      ex_funct   <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_illegal <= 1'b0;
    end else if (!ext_stall) begin
      ex_valid   <= 1'b1;
      ex_ctrl    <= dec_ctrl;
      ex_funct   <= id_funct;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_illegal <= dec_illegal;
    end
  end

  assign ex_ALUOp    = ex_ctrl.aluop;
  assign ex_RegDst   = ex_ctrl.regdst;
  assign ex_ALUSrc   = ex_ctrl.alusrc;
  assign ex_MemRead  = ex_ctrl.memread;
  assign ex_MemWrite = ex_ctrl.memwrite;
  assign ex_RegWrite = ex_ctrl.regwrite;
  assign ex_MemtoReg = ex_ctrl.memtoreg;
  assign ex_Branch   = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// tb/tb_id_ex_control_stage.sv - scoreboard bench for id_ex_control_stage
module tb_id_ex_control_stage;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // control bit order: RegDst ALUSrc MemRead MemWrite RegWrite MemtoReg Branch
  localparam logic [6:0] C_R    = 7'b1000100;
  localparam logic [6:0] C_LW   = 7'b0110110;
  localparam logic [6:0] C_SW   = 7'b0101000;
  localparam logic [6:0] C_BEQ  = 7'b0000001;
  localparam logic [6:0] C_IMM  = 7'b0100100;
  localparam logic [6:0] C_NONE = 7'b0000000;

  localparam logic [33:0] BUB = 34'd0;

  logic clk = 1'b0;
  logic rst, id_valid, flush, ext_stall;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic hazard_stall, id_jump, ex_valid;
  logic [3:0] ex_ALUOp;
  logic [5:0] ex_funct;
  logic ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic ex_illegal;

  int passed = 0;
  int total  = 0;

  logic [1:0]  qc[$];
  logic [33:0] qr[$];

  always #5 clk = ~clk;

  id_ex_control_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .ext_stall(ext_stall),
    .hazard_stall(hazard_stall), .id_jump(id_jump), .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp),
    .ex_funct(ex_funct), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_Branch(ex_Branch), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_illegal(ex_illegal)
  );

  function automatic logic [33:0] exv(input logic [3:0] aop, input logic [6:0] c,
                                      input logic [5:0] fn, input logic [4:0] s, t, d,
                                      input logic ill);
    return {1'b1, aop, c, fn, s, t, d, ill};
  endfunction

  task automatic step(input logic r, v, input logic [5:0] op, fn, input logic [4:0] s, t, d,
                      input logic fl, st, hz, jp, input logic [33:0] ex);
    @(negedge clk);
    rst = r; id_valid = v; id_opcode = op; id_funct = fn;
    id_rs = s; id_rt = t; id_rd = d; flush = fl; ext_stall = st;
    qc.push_back({hz, jp});
    qr.push_back(ex);
  endtask

  // combinational outputs checked mid-cycle
  initial forever begin
    @(negedge clk);
    #2;
    if (qc.size() != 0) begin
      logic [1:0] e;
      e = qc.pop_front();
      total++;
      if ({hazard_stall, id_jump} === e) passed++;
      else $display("FAIL comb t=%0t {hazard_stall,id_jump} got=%b exp=%b", $time, {hazard_stall, id_jump}, e);
    end
  end

  // ID/EX contents checked just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    if (qr.size() != 0) begin
      logic [33:0] e, a;
      e = qr.pop_front();
      a = {ex_valid, ex_ALUOp, ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite,
           ex_MemtoReg, ex_Branch, ex_funct, ex_rs, ex_rt, ex_rd, ex_illegal};
      total++;
      if (a === e) passed++;
      else $display("FAIL idex t=%0t got=%h exp=%h", $time, a, e);
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_opcode = '0; id_funct = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0; ext_stall = 1'b0;
    //    rst v  op    funct      rs  rt  rd  fl st hz jp expected ID/EX
    step(1, 0, R,    6'd0,      0,  0,  0, 0, 0, 0, 0, BUB);
    step(1, 0, R,    6'd0,      0,  0,  0, 0, 0, 0, 0, BUB);
    step(0, 1, ADDI, 6'd0,      1,  2,  0, 0, 0, 0, 0, exv(4'b0000, C_IMM, 6'd0, 1, 2, 0, 0));
    step(0, 1, R,    6'b100010, 3,  4,  5, 0, 0, 0, 0, exv(4'b0010, C_R, 6'b100010, 3, 4, 5, 0));
    // load-use on rs
    step(0, 1, LW,   6'd0,      9,  8,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 9, 8, 0, 0));
    step(0, 1, R,    6'b100000, 8,  4,  6, 0, 0, 1, 0, BUB);
    step(0, 1, R,    6'b100000, 8,  4,  6, 0, 0, 0, 0, exv(4'b0010, C_R, 6'b100000, 8, 4, 6, 0));
    // lw into $0 never stalls
    step(0, 1, LW,   6'd0,      1,  0,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 1, 0, 0, 0));
    step(0, 1, R,    6'b100100, 0,  0,  7, 0, 0, 0, 0, exv(4'b0010, C_R, 6'b100100, 0, 0, 7, 0));
    // load-use on rt (sw)
    step(0, 1, LW,   6'd0,      2, 10,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 2, 10, 0, 0));
    step(0, 1, SW,   6'd0,      3, 10,  0, 0, 0, 1, 0, BUB);
    step(0, 1, SW,   6'd0,      3, 10,  0, 0, 0, 0, 0, exv(4'b0000, C_SW, 6'd0, 3, 10, 0, 0));
    // ext_stall holds sw for 3 cycles, then flush during stall bubbles
    step(0, 1, ADDI, 6'd0,      1,  1,  0, 0, 1, 0, 0, exv(4'b0000, C_SW, 6'd0, 3, 10, 0, 0));
    step(0, 1, ADDI, 6'd0,      1,  1,  0, 0, 1, 0, 0, exv(4'b0000, C_SW, 6'd0, 3, 10, 0, 0));
    step(0, 1, ADDI, 6'd0,      1,  1,  0, 0, 1, 0, 0, exv(4'b0000, C_SW, 6'd0, 3, 10, 0, 0));
    step(0, 1, ADDI, 6'd0,      1,  1,  0, 1, 1, 0, 0, BUB);
    // ext_stall with hazard: hold wins, stall persists
    step(0, 1, LW,   6'd0,      0, 12,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 0, 12, 0, 0));
    step(0, 1, R,    6'b100000, 12, 0,  1, 0, 1, 1, 0, exv(4'b0000, C_LW, 6'd0, 0, 12, 0, 0));
    step(0, 1, R,    6'b100000, 12, 0,  1, 0, 1, 1, 0, exv(4'b0000, C_LW, 6'd0, 0, 12, 0, 0));
    step(0, 1, R,    6'b100000, 12, 0,  1, 0, 0, 1, 0, BUB);
    step(0, 1, R,    6'b100000, 12, 0,  1, 0, 0, 0, 0, exv(4'b0010, C_R, 6'b100000, 12, 0, 1, 0));
    // reset mid-stall
    step(0, 1, LW,   6'd0,      0, 13,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 0, 13, 0, 0));
    step(1, 1, R,    6'b100000, 13, 2,  3, 0, 0, 1, 0, BUB);
    step(0, 1, R,    6'b100000, 13, 2,  3, 0, 0, 0, 0, exv(4'b0010, C_R, 6'b100000, 13, 2, 3, 0));
    // immediate op does not read rt: no stall
    step(0, 1, LW,   6'd0,      0, 14,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 0, 14, 0, 0));
    step(0, 1, ADDI, 6'd0,      2, 14,  0, 0, 0, 0, 0, exv(4'b0000, C_IMM, 6'd0, 2, 14, 0, 0));
    // flush suppresses hazard
    step(0, 1, LW,   6'd0,      0, 15,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 0, 15, 0, 0));
    step(0, 1, R,    6'b100000, 15, 1,  2, 1, 0, 0, 0, BUB);
    // invalid ID slot: no hazard, bubble
    step(0, 1, LW,   6'd0,      0, 16,  0, 0, 0, 0, 0, exv(4'b0000, C_LW, 6'd0, 0, 16, 0, 0));
    step(0, 0, R,    6'b100000, 16, 1,  2, 0, 0, 0, 0, BUB);
    // illegal, jump, remaining opcodes
    step(0, 1, BAD,  6'd0,      0,  0,  0, 0, 0, 0, 0, exv(4'b0000, C_NONE, 6'd0, 0, 0, 0, 1));
    step(0, 1, J,    6'd0,      0,  0,  0, 0, 0, 0, 1, exv(4'b0000, C_NONE, 6'd0, 0, 0, 0, 0));
    step(0, 0, J,    6'd0,      0,  0,  0, 0, 0, 0, 0, BUB);
    step(0, 1, BEQ,  6'd0,      1,  2,  0, 0, 0, 0, 0, exv(4'b0001, C_BEQ, 6'd0, 1, 2, 0, 0));
    step(0, 1, ANDI, 6'd0,      4,  5,  0, 0, 0, 0, 0, exv(4'b0011, C_IMM, 6'd0, 4, 5, 0, 0));
    step(0, 1, ORI,  6'd0,      6,  7,  0, 0, 0, 0, 0, exv(4'b0100, C_IMM, 6'd0, 6, 7, 0, 0));
    step(0, 1, SLTI, 6'd0,      8,  9,  0, 0, 0, 0, 0, exv(4'b0101, C_IMM, 6'd0, 8, 9, 0, 0));
    step(0, 0, R,    6'd0,      0,  0,  0, 0, 0, 0, 0, BUB);
    repeat (3) @(negedge clk);
    total++;
    if (qc.size() == 0 && qr.size() == 0) passed++;
    else $display("FAIL drain qc=%0d qr=%0d exp=0", qc.size(), qr.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_control_stage.md
Name: id_ex_control_stage

Overview:
- Producer side of the ALUOp/funct interface.
- Decodes the ID-stage opcode into ALUOp and the datapath control bits, then registers them with funct and register specifiers into the ID/EX pipeline register.
- Detects load-use hazards: inserts bubbles and emits the stall for PC and IF/ID.
- The downstream ALU-control decoder consumes ex_ALUOp and ex_funct directly.

Parameters:
- REG_W, 5, register specifier width.
- OP_W, 6, opcode/funct width.
- AOP_W, 4, ALUOp width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  IF/ID holds a real instruction.
- id_opcode  input  6  instr[31:26].
- id_funct  input  6  instr[5:0].
- id_rs  input  5  instr[25:21].
- id_rt  input  5  instr[20:16].
- id_rd  input  5  instr[15:11].
- flush  input  1  branch/jump squash of the ID-stage instruction.
- ext_stall  input  1  downstream hold; freezes ID/EX.
- hazard_stall  output  1  combinational; holds PC and IF/ID.
- id_jump  output  1  combinational; opcode==j and id_valid.
- ex_valid  output  1  ID/EX holds a real instruction.
- ex_ALUOp  output  4  registered ALUOp.
- ex_funct  output  6  registered funct.
- ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch  output  1 each  registered control bits.
- ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers.
- ex_illegal  output  1  registered; ID/EX slot came from an unknown opcode.

Behaviour:
- Decode table (opcode -> ALUOp, RegDst, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch):
  - 000000 R-type -> 0010,1,0,0,0,1,0,0
  - 100011 lw -> 0000,0,1,1,0,1,1,0
  - 101011 sw -> 0000,0,1,0,1,0,0,0
  - 000100 beq -> 0001,0,0,0,0,0,0,1
  - 001000 addi -> 0000,0,1,0,0,1,0,0
  - 001100 andi -> 0011,0,1,0,0,1,0,0
  - 001101 ori -> 0100,0,1,0,0,1,0,0
  - 001010 slti -> 0101,0,1,0,0,1,0,0
  - 000010 j -> all zero, id_jump=1
  - other -> all zero, illegal=1
- Bubble: ex_valid=0, all control bits 0, ALUOp 0000, funct/specifiers 0, ex_illegal 0.
- Register uses:
  - uses_rs = R, lw, sw, beq, addi, andi, ori, slti.
  - uses_rt = R, sw, beq.
- hazard_stall = id_valid & ex_valid & ex_MemRead & ex_rt!=0 & ((uses_rs & id_rs==ex_rt) | (uses_rt & id_rt==ex_rt)) & !flush.
- Per-edge priority (exactly one applies):
  - rst: bubble.
  - else flush: bubble.
  - else ext_stall: hold all ID/EX outputs unchanged.
  - else hazard_stall: bubble.
  - else id_valid: load the decoded instruction; ex_illegal = illegal.
  - else: bubble.
- Output timing:
  - Decode-to-EX latency is 1 cycle.
  - hazard_stall is asserted for exactly 1 cycle per load-use pair. The next cycle's ID/EX holds the bubble, so ex_MemRead=0 releases it.
  - hazard_stall and id_jump are 0 whenever id_valid=0.
- Boundary cases:
  - ex_stall together with hazard: hold wins. hazard_stall stays high while ext_stall is high (lw still in EX).
  - lw into $0: no stall.
  - Reset mid-stall: ID/EX is a bubble next cycle and hazard_stall drops.
  - All outputs are 0 after reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J.
  - ALUOp constants: AOP_ADD=0000, AOP_SUB=0001, AOP_RTYPE=0010, AOP_AND=0011, AOP_OR=0100, AOP_SLT=0101.
  - a packed control-bundle struct.
- One combinational sub-module, main_decoder: opcode -> bundle, uses_rs, uses_rt, jump, illegal.
- Hazard logic and the ID/EX register stay in the top level.

Test Plan:
- Reset then addi (001000), rs=1, rt=2 -> next cycle ex_ALUOp=0000, ex_ALUSrc=1, ex_RegWrite=1, ex_valid=1, hazard_stall=0.
- R-type funct 100010, rs=3, rt=4, rd=5 -> ex_ALUOp=0010, ex_funct=100010, ex_RegDst=1, ex_rd=5.
- lw rt=8, then R-type rs=8 -> hazard_stall=1 for 1 cycle. ID/EX is a bubble with ex_MemRead=0. Next cycle the R-type loads with ex_rs=8.
- lw rt=0, then R-type rs=0 -> hazard_stall=0. The R-type loads the cycle after the lw.
- ext_stall=1 for 3 cycles with sw in ID/EX -> ex_MemWrite=1 held constant. flush asserted during the stall -> bubble next edge.
- opcode 111111 -> ex_illegal=1, ex_RegWrite=0, ex_MemWrite=0. j (000010) -> id_jump=1 combinationally, ID/EX gets all-zero controls.
